// File: rtl/ai_fifo_counted.sv
// Single-clock synchronous FIFO with an occupancy counter, threshold flags,
// registered read data with a valid strobe, flush, and sticky error flags.
module ai_fifo_counted #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AF_LEVEL   = DEPTH - 4,
    parameter int unsigned AE_LEVEL   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         w_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         r_en,
    input  logic                         clr_err,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_valid,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         w_ptr;
    logic [AW-1:0]         r_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Status flags are pure decodes of the count register.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    assign wr_ok = w_en && !full;
    assign rd_ok = r_en && !empty;

    // Storage array carries no reset; writes are blocked during rst and flush.
    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_ok) begin
            mem[w_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr      <= '0;
            r_ptr      <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (flush) begin
            w_ptr      <= '0;
            r_ptr      <= '0;
            count      <= '0;
            data_valid <= 1'b0;
        end else begin
            // A new error event wins over a same-cycle clear.
            overflow  <= (w_en && full)  || (overflow  && !clr_err);
            underflow <= (r_en && empty) || (underflow && !clr_err);
            data_valid <= rd_ok;
            if (wr_ok) begin
                w_ptr <= w_ptr + AW'(1);
            end
            if (rd_ok) begin
                data_out <= mem[r_ptr];
                r_ptr    <= r_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ai_fifo_counted.sv
// Directed and randomized checks of ai_fifo_counted against a queue-based model.
module tb_ai_fifo_counted;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned AFL   = 6;
    localparam int unsigned AEL   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          w_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          r_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [3:0]    count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_dv = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    ai_fifo_counted #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in),
        .r_en(r_en), .clr_err(clr_err), .data_out(data_out),
        .data_valid(data_valid), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, "_count"},     32'(count),        32'(sz));
        chk({tag, "_empty"},     32'(empty),        32'(sz == 0));
        chk({tag, "_full"},      32'(full),         32'(sz == DEPTH));
        chk({tag, "_afull"},     32'(almost_full),  32'(sz >= AFL));
        chk({tag, "_aempty"},    32'(almost_empty), 32'(sz <= AEL));
        chk({tag, "_dout"},      32'(data_out),     32'(m_dout));
        chk({tag, "_dvalid"},    32'(data_valid),   32'(m_dv));
        chk({tag, "_overflow"},  32'(overflow),     32'(m_ovf));
        chk({tag, "_underflow"}, 32'(underflow),    32'(m_unf));
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                        input bit fl, input bit ce, input bit rs, input string tag);
        bit ev_o, ev_u, do_wr, do_rd;
        w_en = w; data_in = d; r_en = r; flush = fl; clr_err = ce; rst = rs;
        if (rs) begin
            q.delete();
            m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (fl) begin
            q.delete();
            m_dv = 1'b0;
        end else begin
            ev_o  = w && (q.size() == DEPTH);
            ev_u  = r && (q.size() == 0);
            do_wr = w && (q.size() < DEPTH);
            do_rd = r && (q.size() > 0);
            if (do_rd) m_dout = q.pop_front();
            m_dv = do_rd;
            if (do_wr) q.push_back(d);
            m_ovf = ev_o || (m_ovf && !ce);
            m_unf = ev_u || (m_unf && !ce);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset
        step(0, 8'h00, 0, 0, 0, 1, "reset");
        step(0, 8'h00, 0, 0, 0, 0, "idle");

        // Fill 0x01..0x08, then a ninth write overflows
        for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0, 0, 0, "fill");
        chk("fill_full_const", 32'(full), 32'd1);
        step(1, 8'h99, 0, 0, 0, 0, "fill_ovf");
        chk("ovf_const", 32'(overflow), 32'd1);

        // Drain, then a ninth read underflows and data_out holds 0x08
        for (int i = 1; i <= 8; i++) step(0, 8'h00, 1, 0, 0, 0, "drain");
        step(0, 8'h00, 1, 0, 0, 0, "drain_unf");
        chk("unf_dout_const", 32'(data_out), 32'h08);
        step(0, 8'h00, 0, 0, 1, 0, "clr_err");

        // Simultaneous access at full and at empty
        for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0, 0, 0, "refill");
        step(1, 8'hAA, 1, 0, 0, 0, "both_full");
        chk("both_full_dout_const", 32'(data_out), 32'h01);
        for (int i = 0; i < 7; i++) step(0, 8'h00, 1, 0, 0, 0, "drain2");
        step(1, 8'h55, 1, 0, 0, 0, "both_empty");
        step(0, 8'h00, 1, 0, 0, 0, "read_55");

        // Wrap-around: concurrent traffic at count 4
        for (int i = 0; i < 4; i++) step(1, DW'(8'h10 + i), 0, 0, 0, 0, "prewrap");
        for (int i = 0; i < 20; i++) step(1, DW'(8'h20 + i), 1, 0, 0, 0, "wrap");

        // Flush at count 5 with w_en+r_en
        step(1, 8'h77, 0, 0, 0, 0, "to5");
        step(1, 8'h88, 1, 1, 0, 0, "flush");
        chk("flush_empty_const", 32'(empty), 32'd1);

        // clr_err together with a new overflow event
        for (int i = 0; i < 8; i++) step(1, DW'(8'h40 + i), 0, 0, 0, 0, "fill3");
        step(1, 8'hEE, 0, 0, 0, 0, "ovf_again");
        step(1, 8'hEF, 0, 0, 1, 0, "clr_vs_ovf");
        chk("clr_vs_ovf_const", 32'(overflow), 32'd1);
        step(0, 8'h00, 0, 1, 0, 0, "flush2");
        step(0, 8'h00, 0, 0, 1, 0, "clr2");

        // Reset during a write burst at count 3
        for (int i = 0; i < 3; i++) step(1, DW'(8'h60 + i), 0, 0, 0, 0, "burst");
        step(1, 8'h63, 1, 1, 1, 1, "mid_reset");
        step(1, 8'hC1, 0, 0, 0, 0, "post_wr");
        step(0, 8'h00, 1, 0, 0, 0, "post_rd");
        chk("post_rd_const", 32'(data_out), 32'hC1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ai_fifo_counted.md
AI_FIFO_COUNTED -- requirements
Module: ai_fifo_counted

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of storage entries; power of two, >= 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  synchronous empty-the-FIFO request.
REQ-008 SHALL have port w_en  input  1  write request.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-010 SHALL have port r_en  input  1  read request.
REQ-011 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-012 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-013 SHALL have port data_valid  output  1  one-cycle strobe: data_out updated this cycle.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL store up to DEPTH words; full = (count == DEPTH), empty = (count == 0), all flags decoded from the count register only.
REQ-018 SHALL accept a write iff w_en && !full, storing data_in at w_ptr and advancing w_ptr modulo DEPTH.
REQ-019 SHALL accept a read iff r_en && !empty, loading mem[r_ptr] into data_out on that edge, pulsing data_valid high the following cycle, advancing r_ptr modulo DEPTH.
REQ-020 SHALL hold data_out unchanged and drive data_valid low in every cycle with no accepted read.
REQ-021 SHALL update count: +1 write only, -1 read only, unchanged for both or neither.
REQ-022 SHALL, with simultaneous w_en and r_en while full, accept only the read (count -> DEPTH-1); while empty, accept only the write (count -> 1, data_valid stays low).
REQ-023 SHALL, with simultaneous accepted write and read at 0 < count < DEPTH, perform both; count unchanged.
REQ-024 SHALL set overflow on w_en && full and underflow on r_en && empty; both remain set until clr_err or rst.
REQ-025 SHALL give a new error event priority over clr_err in the same cycle (flag stays/sets to 1).
REQ-026 SHALL, on flush, set w_ptr, r_ptr, count to 0 and data_valid to 0, ignore w_en/r_en that cycle, keep data_out and error flags unchanged.
REQ-027 SHALL preserve FIFO ordering across pointer wrap-around for any number of wraps.

Reset
REQ-028 SHALL, on rst high at a clock edge, set w_ptr, r_ptr, count, data_out, data_valid, overflow, underflow to 0, yielding empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 SHALL give rst priority over flush, clr_err, w_en and r_en, including reset asserted mid-burst.
REQ-030 SHALL not require memory array contents to be reset.

Verification (DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-031 SHALL cover fill: write 0x01..0x08 -> count 1..8, almost_empty drops at count 3, almost_full rises at 6, full at 8; 9th w_en -> overflow=1, count stays 8.
REQ-032 SHALL cover drain: read 8 times after fill -> data_out 0x01..0x08, each one cycle after r_en, data_valid high 8 cycles; 9th r_en -> underflow=1, data_out stays 0x08.
REQ-033 SHALL cover simultaneous access: at count 8 assert w_en(0xAA)+r_en -> count 7, data_out 0x01; at count 0 both -> count 1, data_valid 0.
REQ-034 SHALL cover wrap: 20 cycles of concurrent write/read at count 4 with incrementing data -> outputs strictly in order, count constant 4.
REQ-035 SHALL cover flush with w_en+r_en at count 5 -> next cycle count 0, empty=1, data_valid 0, data_out unchanged; clr_err with simultaneous overflow event -> overflow stays 1.
REQ-036 SHALL cover reset mid-operation: rst during write burst at count 3 -> next cycle count 0, all outputs at reset values, subsequent write/read returns new data only.
